// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } ifu_entry_t;

    localparam int unsigned ENTRY_W = $bits(ifu_entry_t);

endpackage

// File: rtl/ifu_buf.sv
// Synchronous FIFO with flush; head is presented directly from storage.
module ifu_buf #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign rdata   = mem[rd_ptr];
    assign pop_ok  = pop && (count != '0);
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, capped memory requests, response buffering, redirect flush.
// Optional IFU_MISALIGN_TRAP_EN adds id_fault and halts on a misaligned redirect.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_pc_plus4
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic               id_fault
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  redirect_tgt;
    logic [XLEN-1:0]  rsp_pc;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occ;
    logic [SUM_W-1:0] committed;
    logic             issue;
    logic             accept;
    logic             buf_push;
    logic             halt;
    ifu_entry_t       push_entry;
    ifu_entry_t       head_entry;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign committed    = SUM_W'(inflight) + SUM_W'(occ);
    assign imem_req     = rstn && !redirect_valid && !halt && (committed < SUM_W'(BUF_DEPTH));
    assign imem_addr    = pc_q;
    assign issue        = imem_req && imem_gnt;
    assign accept       = imem_rvalid && (drop_q == '0) && !redirect_valid;

`ifdef IFU_MISALIGN_TRAP_EN
    logic            halt_q;
    logic            pend_q;
    logic [XLEN-1:0] fault_pc_q;
    logic            fault_push;

    // Once everything outstanding has drained, inject the single trap marker.
    assign fault_push = halt_q && pend_q && (inflight == '0) && !redirect_valid;
    assign halt       = halt_q;
    assign buf_push   = accept || fault_push;
    assign push_entry = fault_push ? ifu_entry_t'{instr: NOP_INSTR, pc: fault_pc_q}
                                   : ifu_entry_t'{instr: imem_rdata, pc: rsp_pc};
    assign id_fault   = halt_q && id_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            halt_q     <= 1'b0;
            pend_q     <= 1'b0;
            fault_pc_q <= '0;
        end else if (redirect_valid) begin
            halt_q     <= (redirect_pc[1:0] != 2'b00);
            pend_q     <= (redirect_pc[1:0] != 2'b00);
            fault_pc_q <= redirect_pc;
        end else if (fault_push) begin
            pend_q <= 1'b0;
        end
    end
`else
    assign halt       = 1'b0;
    assign buf_push   = accept;
    assign push_entry = ifu_entry_t'{instr: imem_rdata, pc: rsp_pc};
`endif

    // PCs of requests in flight; its occupancy is the in-flight count.
    ifu_buf #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pcq (
        .clk   (clk),
        .rstn  (rstn),
        .flush (1'b0),
        .push  (issue),
        .wdata (pc_q),
        .pop   (imem_rvalid),
        .rdata (rsp_pc),
        .count (inflight)
    );

    ifu_buf #(.WIDTH(ENTRY_W), .DEPTH(BUF_DEPTH)) u_ibuf (
        .clk   (clk),
        .rstn  (rstn),
        .flush (redirect_valid),
        .push  (buf_push),
        .wdata (push_entry),
        .pop   (id_valid && id_ready),
        .rdata (head_entry),
        .count (occ)
    );

    assign id_valid    = (occ != '0);
    assign id_instr    = head_entry.instr;
    assign id_pc       = head_entry.pc;
    assign id_pc_plus4 = head_entry.pc + XLEN'(4);

    // A redirect marks every still-outstanding response (minus one returning now) for discard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else if (redirect_valid) begin
            pc_q   <= redirect_tgt;
            drop_q <= inflight - CNT_W'(imem_rvalid);
        end else begin
            if (issue) pc_q <= pc_q + XLEN'(4);
            if (imem_rvalid && (drop_q != '0)) drop_q <= drop_q - CNT_W'(1);
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage that feeds the decode stage: keeps the PC, issues word fetches to instruction memory, and buffers returned words with their PCs.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Accepts a redirect (branch/jal/jalr target) from the next-PC logic and flushes all stale work.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the cap on buffered + in-flight fetches (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address (word aligned).
- imem_gnt  in  1  request accepted this cycle (req&gnt = issued).
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- id_valid  out  1  buffer head valid.
- id_ready  in  1  decode accepts head.
- id_instr  out  32  instruction at head; decode slices opcode [6:0], funct3 [14:12], funct7 [31:25].
- id_pc  out  32  PC of head.
- id_pc_plus4  out  32  id_pc + 4, mod 2^32.

Behaviour:
- Clock/reset: one clock `clk`; reset `rstn` is asynchronous and active-low.
- Reset values: pc_q = RESET_PC; buffer empty; inflight = 0; drop = 0; imem_req = 0; id_valid = 0; id_instr = 0; id_pc = 0.
- Request generation:
  - imem_req = !redirect_valid && (inflight + occupancy < BUF_DEPTH).
  - imem_addr = pc_q. Req and addr stay stable until gnt.
  - On req&gnt: pc_q += 4 (wraps at 2^32), inflight++.
- Response handling:
  - On rvalid: inflight--.
  - If drop > 0: drop-- and the word is discarded.
  - Otherwise push {imem_rdata, pc} into the buffer. The PC comes from an internal in-flight PC queue, pushed on gnt and popped on rvalid.
  - Push never overflows, guaranteed by the request cap.
- Output:
  - id_valid = buffer not empty; outputs come directly from the head entry.
  - Pop on id_valid&id_ready.
  - Push and pop in the same cycle are both allowed, including when the buffer is full.
  - Latency: gnt at cycle N, rvalid at N+1 → id_valid at N+2 (registered buffer).
- Redirect (priority over everything else that cycle):
  - pc_q ← redirect_pc.
  - Buffer is flushed, so id_valid = 0 next cycle.
  - No request is issued that cycle.
  - drop ← drop + (inflight − drop) − rvalid_this_cycle. Every response still outstanding is discarded, including one arriving in the same cycle.
  - A pop handshake in the same cycle counts as completed before the flush.
- Back-to-back redirects: each one overrides the previous; the drop accounting stays exact.
- Reset asserted mid-operation: all state returns to reset values immediately. Memory responses arriving after reset is released are not the block's concern; the memory side is reset by the same rstn.
- Stall: with id_ready = 0 and the buffer full, imem_req = 0 and pc_q holds.
- Default (macro off): redirect_pc[1:0] is ignored and treated as 00.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port id_fault (1 bit).
  - A redirect with redirect_pc[1:0] != 0 sets a sticky halt flag: no further requests are issued and outstanding responses are dropped.
  - After in-flight responses drain, the buffer presents a single entry: id_instr = 32'h0000_0013 (addi x0,x0,0), id_pc = redirect_pc, id_fault = 1.
  - The halt clears only on the next aligned redirect or on reset.
- Undefined: no id_fault port; low address bits are masked as described in Behaviour.

Decomposition:
- Shared package ifu_pkg:
  - INSTR_W = 32, XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - The typedef of the buffer entry {instr, pc}.
- One natural sub-module: ifu_buf, a synchronous FIFO of BUF_DEPTH entries with flush, push, pop, empty, count. It is instantiated twice: once for the instruction buffer and once for the in-flight PC queue.

Test Plan:
1. Reset, memory always gnt and rvalid one cycle later, id_ready = 1 → addrs 0x0, 0x4, 0x8…; first id_valid at cycle 2 with id_pc = 0x0; then one instruction per cycle; id_pc_plus4 = 0x4.
2. id_ready held 0 for 10 cycles → exactly 2 words buffered, imem_req = 0, pc_q = 0x8. Release id_ready → 0x0 and 0x4 delivered in order with no loss.
3. Redirect to 0x100 while 2 fetches (0x8, 0xC) are in flight → both responses discarded; next id_pc = 0x100, then 0x104.
4. Redirect in the same cycle as rvalid and as a decode pop → popped instruction counts as consumed, returning word dropped, buffer empty next cycle.
5. pc_q = 0xFFFF_FFFC, fetch proceeds → next imem_addr = 0x0; id_pc_plus4 = 0x0.
6. (IFU_MISALIGN_TRAP_EN) redirect to 0x102 → no further imem_req; id_valid with id_instr = 0x13, id_fault = 1, id_pc = 0x102. A later redirect to 0x200 resumes normal fetch.
